// File: rtl/multi_timer_if.sv
// Control and status bundle for multi_timer: per-channel strobes, limits and
// packed count/flag outputs.
interface multi_timer_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]       i_Start;
    logic [N_CH-1:0]       i_Stop;
    logic [N_CH-1:0]       i_Clear;
    logic [N_CH-1:0]       i_Periodic;
    logic [N_CH*CNT_W-1:0] i_Limit;
    logic [N_CH*CNT_W-1:0] o_Count;
    logic [N_CH-1:0]       o_Busy;
    logic [N_CH-1:0]       o_Done;
    logic [N_CH-1:0]       o_DonePulse;
    logic                  o_Tick;

    modport master (
        output i_Start, i_Stop, i_Clear, i_Periodic, i_Limit,
        input  o_Count, o_Busy, o_Done, o_DonePulse, o_Tick
    );

    modport slave (
        input  i_Start, i_Stop, i_Clear, i_Periodic, i_Limit,
        output o_Count, o_Busy, o_Done, o_DonePulse, o_Tick
    );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel timeout timer on clk_50M: shared prescaler tick enable feeding
// N_CH independent one-shot/periodic channels.
module multi_timer_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             periodic_in,
    input  logic [CNT_W-1:0] limit_in,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             done_pulse
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_EXPIRED = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] limit_q;
    logic             periodic_q;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the compare at limit 2^CNT_W-1 cannot wrap.
    always_comb begin
        cnt_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state      <= S_IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (clear) begin
                state <= S_IDLE;
                count <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (stop) begin
                if (state == S_RUN) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            end else if (start) begin
                limit_q    <= limit_in;
                periodic_q <= periodic_in;
                count      <= '0;
                // A zero limit expires immediately instead of running.
                if (limit_in == '0) begin
                    state      <= S_EXPIRED;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    done_pulse <= 1'b1;
                end else begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end
            end else if (tick && state == S_RUN) begin
                if (cnt_inc == {1'b0, limit_q}) begin
                    done_pulse <= 1'b1;
                    done       <= 1'b1;
                    if (periodic_q) begin
                        count <= '0;
                    end else begin
                        count <= limit_q;
                        state <= S_EXPIRED;
                        busy  <= 1'b0;
                    end
                end else begin
                    count <= cnt_inc[CNT_W-1:0];
                end
            end
        end
    end
endmodule

module multi_timer #(
    parameter int N_CH    = 4,
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 2000,
    parameter int CNT_W   = 16
) (
    input  logic          clk_50M,
    input  logic          i_Reset,
    multi_timer_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("multi_timer: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [PW-1:0]                presc;
    logic                         tick;
    logic [N_CH-1:0][CNT_W-1:0]   count_q;
    logic [N_CH-1:0]              busy_q;
    logic [N_CH-1:0]              done_q;
    logic [N_CH-1:0]              pulse_q;

    // Tick is registered one count early so it is high while presc == DIV-1.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= (presc == PW'(DIV - 1)) ? '0 : presc + 1'b1;
            tick  <= (presc == PW'(DIV - 2));
        end
    end

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            multi_timer_ch #(.CNT_W(CNT_W)) u_ch (
                .clk_50M     (clk_50M),
                .i_Reset     (i_Reset),
                .tick        (tick),
                .start       (bus.i_Start[k]),
                .stop        (bus.i_Stop[k]),
                .clear       (bus.i_Clear[k]),
                .periodic_in (bus.i_Periodic[k]),
                .limit_in    (bus.i_Limit[k*CNT_W +: CNT_W]),
                .count       (count_q[k]),
                .busy        (busy_q[k]),
                .done        (done_q[k]),
                .done_pulse  (pulse_q[k])
            );
        end
    endgenerate

    assign bus.o_Count     = count_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_Done      = done_q;
    assign bus.o_DonePulse = pulse_q;
    assign bus.o_Tick      = tick;
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer at DIV=10: tick cadence, one-shot, periodic,
// stop/clear, zero/max limits and mid-run reset.
module tb_multi_timer;
    logic clk_50M = 1'b0;
    logic i_Reset = 1'b1;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   cyc     = 0;

    always #5 clk_50M = ~clk_50M;

    multi_timer_if #(.N_CH(4), .CNT_W(8)) bus ();

    multi_timer #(.N_CH(4), .CLK_HZ(100), .TICK_HZ(10), .CNT_W(8)) dut (
        .clk_50M (clk_50M),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_50M);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic clr_inputs();
        bus.i_Start    = '0;
        bus.i_Stop     = '0;
        bus.i_Clear    = '0;
        bus.i_Periodic = '0;
        bus.i_Limit    = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        i_Reset = 1'b1;
        repeat (2) @(posedge clk_50M);
        @(negedge clk_50M);
        i_Reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [7:0] c0, c1;
        int k;
        clr_inputs();

        // Tick cadence and quiet outputs after reset
        do_reset();
        for (int c = 0; c < 25; c++) begin
            run_to(c);
            chk("tick", bus.o_Tick, (cyc == 9 || cyc == 19));
            chk("idle", {bus.o_Count, bus.o_Busy, bus.o_Done, bus.o_DonePulse}, 64'd0);
        end

        // ch0 one-shot 3 and ch1 periodic 3 started together: simultaneous expiry
        do_reset();
        run_to(2);
        bus.i_Start = 4'b0011; bus.i_Periodic = 4'b0010;
        bus.i_Limit = {8'd0, 8'd0, 8'd3, 8'd3};
        step();
        bus.i_Start = '0;
        for (int c = 3; c <= 35; c++) begin
            run_to(c);
            c0 = (cyc < 10) ? 8'd0 : (cyc < 20) ? 8'd1 : (cyc < 30) ? 8'd2 : 8'd3;
            c1 = (cyc >= 30) ? 8'd0 : c0;
            chk("os_cnt",   bus.o_Count[15:0], {c1, c0});
            chk("os_busy",  bus.o_Busy[1:0], (cyc < 30) ? 2'b11 : 2'b10);
            chk("os_done",  bus.o_Done[1:0], (cyc >= 30) ? 2'b11 : 2'b00);
            chk("os_pulse", bus.o_DonePulse[1:0], (cyc == 30) ? 2'b11 : 2'b00);
        end

        // ch1 periodic 2; limit/mode changes mid-run are ignored
        do_reset();
        run_to(2);
        bus.i_Start = 4'b0010; bus.i_Periodic = 4'b0010;
        bus.i_Limit = {8'd0, 8'd0, 8'd2, 8'd0};
        step();
        bus.i_Start = '0;
        for (int c = 3; c <= 45; c++) begin
            run_to(c);
            if (cyc == 15) begin bus.i_Limit = {8'd0, 8'd0, 8'd7, 8'd0}; bus.i_Periodic = '0; end
            k = cyc / 10;
            chk("per_cnt",   bus.o_Count[15:8], k % 2);
            chk("per_busy",  bus.o_Busy[1], 1'b1);
            chk("per_done",  bus.o_Done[1], k >= 2);
            chk("per_pulse", bus.o_DonePulse[1], (cyc % 10 == 0) && k >= 2 && (k % 2 == 0));
        end

        // ch2 stop freezes, clear zeroes, clear beats start
        do_reset();
        run_to(2);
        bus.i_Start = 4'b0100; bus.i_Limit = {8'd0, 8'd5, 8'd0, 8'd0};
        step();
        bus.i_Start = '0;
        run_to(20);
        chk("stp_pre_cnt",  bus.o_Count[23:16], 8'd2);
        chk("stp_pre_busy", bus.o_Busy[2], 1'b1);
        run_to(21);
        bus.i_Stop = 4'b0100;
        step();
        bus.i_Stop = '0;
        for (int c = 22; c <= 35; c++) begin
            run_to(c);
            chk("stp_cnt",  bus.o_Count[23:16], 8'd2);
            chk("stp_busy", bus.o_Busy[2], 1'b0);
        end
        bus.i_Clear = 4'b0100;
        step();
        bus.i_Clear = '0;
        chk("clr_cnt", bus.o_Count[23:16], 8'd0);
        bus.i_Start = 4'b0100; bus.i_Clear = 4'b0100;
        step();
        bus.i_Start = '0; bus.i_Clear = '0;
        for (int c = 37; c <= 45; c++) begin
            run_to(c);
            chk("clrwin_cnt",  bus.o_Count[23:16], 8'd0);
            chk("clrwin_busy", bus.o_Busy[2], 1'b0);
        end

        // ch3 zero limit, then max limit without wrap
        do_reset();
        run_to(2);
        bus.i_Start = 4'b1000; bus.i_Limit = '0;
        step();
        bus.i_Start = '0;
        chk("z_pulse", bus.o_DonePulse[3], 1'b1);
        chk("z_done",  bus.o_Done[3], 1'b1);
        chk("z_cnt",   bus.o_Count[31:24], 8'd0);
        chk("z_busy",  bus.o_Busy[3], 1'b0);
        step();
        chk("z_pulse2", bus.o_DonePulse[3], 1'b0);
        chk("z_done2",  bus.o_Done[3], 1'b1);
        bus.i_Start = 4'b1000; bus.i_Limit = {8'd255, 8'd0, 8'd0, 8'd0};
        step();
        bus.i_Start = '0;
        chk("m_done_clr", bus.o_Done[3], 1'b0);
        chk("m_busy",     bus.o_Busy[3], 1'b1);
        run_to(2549);
        chk("m_cnt254",  bus.o_Count[31:24], 8'd254);
        chk("m_pulse0",  bus.o_DonePulse[3], 1'b0);
        step();
        chk("m_cnt255",  bus.o_Count[31:24], 8'd255);
        chk("m_pulse",   bus.o_DonePulse[3], 1'b1);
        chk("m_done",    bus.o_Done[3], 1'b1);
        chk("m_busy0",   bus.o_Busy[3], 1'b0);
        run_to(2565);
        chk("m_nowrap",  bus.o_Count[31:24], 8'd255);
        chk("m_pulse1",  bus.o_DonePulse[3], 1'b0);

        // Reset mid-run aborts ch0 and restarts the prescaler
        do_reset();
        run_to(2);
        bus.i_Start = 4'b0001; bus.i_Limit = {8'd0, 8'd0, 8'd0, 8'd3};
        step();
        bus.i_Start = '0;
        run_to(20);
        chk("r_pre_cnt", bus.o_Count[7:0], 8'd2);
        run_to(25);
        i_Reset = 1'b1;
        step();
        chk("r_outs", {bus.o_Count, bus.o_Busy, bus.o_Done, bus.o_DonePulse, bus.o_Tick}, 64'd0);
        i_Reset = 1'b0;
        cyc = 0;
        run_to(8);
        chk("r_tick8", bus.o_Tick, 1'b0);
        step();
        chk("r_tick9", bus.o_Tick, 1'b1);
        for (int c = 10; c <= 32; c++) begin
            run_to(c);
            chk("r_quiet", {bus.o_Count[7:0], bus.o_Busy[0], bus.o_Done[0], bus.o_DonePulse[0]}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
